// File: rtl/shared_ram_mcfifo.sv
// Multi-channel FIFO: all channels share one single-port RAM, served one
// request at a time by a fixed-priority or round-robin arbiter.
module shared_ram_mcfifo #(
    parameter int pChannels  = 2,
    parameter int pWidth     = 8,
    parameter int pDepthBits = 2,
    parameter int pRR        = 0
) (
    input  logic                                 Clk,
    input  logic                                 Rst_N,
    input  logic [pChannels-1:0]                 Ch_Rst,
    input  logic [pChannels-1:0]                 Wr,
    input  logic [pChannels-1:0]                 Rd,
    input  logic [pChannels*pWidth-1:0]          DI,
    output logic [pChannels*pWidth-1:0]          DO,
    output logic [pChannels-1:0]                 EF,
    output logic [pChannels-1:0]                 FF,
    output logic [pChannels*(pDepthBits+1)-1:0]  Cnt,
    output logic [pChannels-1:0]                 WrAck,
    output logic [pChannels-1:0]                 RdAck,
    output logic [pChannels-1:0]                 Err,
    output logic                                 Busy
);
    localparam int DEPTH = 2**pDepthBits;
    localparam int NSRC  = 2*pChannels;
    localparam int CW    = (pChannels > 1) ? $clog2(pChannels) : 1;
    localparam int SW    = $clog2(NSRC);
    localparam int AW    = CW + pDepthBits;
    localparam logic [pDepthBits:0] FULL_CNT = (pDepthBits+1)'(DEPTH);
    localparam logic [pDepthBits:0] ONE_CNT  = (pDepthBits+1)'(1);
    localparam logic [pDepthBits-1:0] ONE_PTR = pDepthBits'(1);

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        WR   = 4'b0010,
        RD   = 4'b0100,
        LD   = 4'b1000
    } state_t;

    state_t                 state, state_nxt;
    logic [pDepthBits-1:0]  wptr    [pChannels];
    logic [pDepthBits-1:0]  rptr    [pChannels];
    logic [pDepthBits:0]    cnt     [pChannels];
    logic [pWidth-1:0]      do_r    [pChannels];
    logic [pWidth-1:0]      wr_hold [pChannels];
    logic [pChannels-1:0]   wr_pnd, rd_pnd, err, wr_ack, rd_ack;
    logic [CW-1:0]          cur_ch;
    logic [SW-1:0]          rr_next;

    logic [pWidth-1:0]      mem [pChannels*DEPTH];
    logic [pWidth-1:0]      ram_q;
    logic [AW-1:0]          ram_addr;
    logic                   ram_we;

    logic [NSRC-1:0]        req;
    logic [SW-1:0]          rr_idx, gnt_src;
    logic [CW-1:0]          gnt_ch;
    logic                   gnt_vld, gnt_wr, gnt_drop;

    // Sources 0..N-1 are writes, N..2N-1 are reads; a channel being flushed never wins.
    always_comb begin
        req     = {rd_pnd & ~Ch_Rst, wr_pnd & ~Ch_Rst};
        gnt_vld = 1'b0;
        gnt_src = '0;
        rr_idx  = '0;
        if (pRR != 0) begin
            for (int k = 0; k < NSRC; k++) begin
                rr_idx = SW'((int'(rr_next) + k) % NSRC);
                if (!gnt_vld && req[rr_idx]) begin
                    gnt_vld = 1'b1;
                    gnt_src = rr_idx;
                end
            end
        end else begin
            for (int c = 0; c < pChannels; c++) begin
                if (!gnt_vld && req[c]) begin
                    gnt_vld = 1'b1;
                    gnt_src = SW'(c);
                end
            end
            for (int c = pChannels-1; c >= 0; c--) begin
                if (!gnt_vld && req[pChannels+c]) begin
                    gnt_vld = 1'b1;
                    gnt_src = SW'(pChannels + c);
                end
            end
        end
        gnt_wr   = int'(gnt_src) < pChannels;
        gnt_ch   = gnt_wr ? CW'(gnt_src) : CW'(int'(gnt_src) - pChannels);
        gnt_drop = gnt_wr ? (cnt[gnt_ch] == FULL_CNT) : (cnt[gnt_ch] == '0);
    end

    always_ff @(posedge Clk) begin
        if (!Rst_N) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (gnt_vld && !gnt_drop) state_nxt = gnt_wr ? WR : RD;
            WR:   state_nxt = IDLE;
            RD:   state_nxt = (!Ch_Rst[cur_ch] && cnt[cur_ch] > ONE_CNT) ? LD : IDLE;
            LD:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Single RAM port: write slot in WR, prefetch of the next head in RD.
    always_comb begin
        ram_we   = (state == WR) && !Ch_Rst[cur_ch];
        ram_addr = (state == WR) ? {cur_ch, wptr[cur_ch]}
                                 : {cur_ch, rptr[cur_ch] + ONE_PTR};
    end

    always_ff @(posedge Clk) begin
        if (ram_we) mem[ram_addr] <= wr_hold[cur_ch];
        ram_q <= mem[ram_addr];
    end

    always_ff @(posedge Clk) begin
        if (!Rst_N) begin
            for (int c = 0; c < pChannels; c++) begin
                wptr[c] <= '0;
                rptr[c] <= '0;
                cnt[c]  <= '0;
                do_r[c] <= '0;
            end
            wr_pnd  <= '0;
            rd_pnd  <= '0;
            err     <= '0;
            wr_ack  <= '0;
            rd_ack  <= '0;
            cur_ch  <= '0;
            rr_next <= '0;
        end else begin
            wr_ack <= '0;
            rd_ack <= '0;
            for (int c = 0; c < pChannels; c++) begin
                if (Wr[c]) begin
                    if (wr_pnd[c]) err[c] <= 1'b1;
                    else begin
                        wr_pnd[c]  <= 1'b1;
                        wr_hold[c] <= DI[c*pWidth +: pWidth];
                    end
                end
                if (Rd[c]) begin
                    if (rd_pnd[c]) err[c] <= 1'b1;
                    else           rd_pnd[c] <= 1'b1;
                end
            end
            if (state == IDLE && gnt_vld) begin
                cur_ch  <= gnt_ch;
                rr_next <= (int'(gnt_src) == NSRC-1) ? '0 : gnt_src + SW'(1);
                if (gnt_drop) begin
                    if (gnt_wr) wr_pnd[gnt_ch] <= 1'b0;
                    else        rd_pnd[gnt_ch] <= 1'b0;
                end
            end
            if (!Ch_Rst[cur_ch]) begin
                case (state)
                    WR: begin
                        wptr[cur_ch]   <= wptr[cur_ch] + ONE_PTR;
                        cnt[cur_ch]    <= cnt[cur_ch] + ONE_CNT;
                        if (cnt[cur_ch] == '0) do_r[cur_ch] <= wr_hold[cur_ch];
                        wr_pnd[cur_ch] <= 1'b0;
                        wr_ack[cur_ch] <= 1'b1;
                    end
                    RD: begin
                        rptr[cur_ch]   <= rptr[cur_ch] + ONE_PTR;
                        cnt[cur_ch]    <= cnt[cur_ch] - ONE_CNT;
                        rd_pnd[cur_ch] <= 1'b0;
                        if (cnt[cur_ch] == ONE_CNT) rd_ack[cur_ch] <= 1'b1;
                    end
                    LD: begin
                        do_r[cur_ch]   <= ram_q;
                        rd_ack[cur_ch] <= 1'b1;
                    end
                    default: ;
                endcase
            end
            // Flush has the last word over anything latched or served this cycle.
            for (int c = 0; c < pChannels; c++) begin
                if (Ch_Rst[c]) begin
                    wptr[c]   <= '0;
                    rptr[c]   <= '0;
                    cnt[c]    <= '0;
                    do_r[c]   <= '0;
                    wr_pnd[c] <= 1'b0;
                    rd_pnd[c] <= 1'b0;
                    err[c]    <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        for (int c = 0; c < pChannels; c++) begin
            DO[c*pWidth +: pWidth]                 = do_r[c];
            Cnt[c*(pDepthBits+1) +: pDepthBits+1]  = cnt[c];
            EF[c]                                  = (cnt[c] == '0);
            FF[c]                                  = (cnt[c] == FULL_CNT);
        end
    end

    assign WrAck = wr_ack;
    assign RdAck = rd_ack;
    assign Err   = err;
    assign Busy  = (state != IDLE);

endmodule
